// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master Avalon-style bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] BUS_ABORT_DATA = 32'hDEADBEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/bus_watchdog.sv
// Stall counter for one granted transaction; hit flags the abort cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam logic [15:0] LIMIT   = 16'(TIMEOUT_CYCLES);
    localparam logic        ENABLED = (TIMEOUT_CYCLES != 32'd0);

    logic [15:0] count_r;

    // Stalled-cycle counter, held at zero while the arbiter is idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (enable) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = ENABLED && (count_r == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-style memory slave,
// with a watchdog that aborts transactions the slave stalls for too long.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clear
);

    arb_state_e state_r;
    logic [1:0] grant_r;
    logic       last_grant_r;
    logic       timeout_err_r;

    logic req0_s;
    logic req1_s;
    logic in_gnt_s;
    logic hit_s;
    logic abort_s;

    assign req0_s   = m0_read | m0_write;
    assign req1_s   = m1_read | m1_write;
    assign in_gnt_s = (state_r != ST_IDLE);
    assign abort_s  = in_gnt_s & hit_s;

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (~in_gnt_s),
        .enable (in_gnt_s & s_waitrequest & ~hit_s),
        .hit    (hit_s)
    );

    // Route the owner's request to the slave; abort suppresses strobes and answers the master
    always_comb begin
        s_address      = 32'd0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'd0;
        s_byteenable   = 4'd0;
        m0_waitrequest = 1'b1;
        m0_readdata    = 32'd0;
        m1_waitrequest = 1'b1;
        m1_readdata    = 32'd0;
        case (state_r)
            ST_GNT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write & ~hit_s;
                s_read         = m0_read & ~m0_write & ~hit_s;
                m0_waitrequest = hit_s ? 1'b0 : s_waitrequest;
                m0_readdata    = hit_s ? BUS_ABORT_DATA : s_readdata;
            end
            ST_GNT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write & ~hit_s;
                s_read         = m1_read & ~m1_write & ~hit_s;
                m1_waitrequest = hit_s ? 1'b0 : s_waitrequest;
                m1_readdata    = hit_s ? BUS_ABORT_DATA : s_readdata;
            end
            default: begin
                s_address = 32'd0;
            end
        endcase
    end

    // Arbiter FSM with registered grant, round-robin history and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= GRANT_NONE;
            last_grant_r  <= 1'b1;
            timeout_err_r <= 1'b0;
        end else begin
            if (abort_s) begin
                timeout_err_r <= 1'b1;
            end else if (err_clear) begin
                timeout_err_r <= 1'b0;
            end else begin
                timeout_err_r <= timeout_err_r;
            end

            case (state_r)
                ST_IDLE: begin
                    // On a tie the master not served last wins
                    if (req0_s && (!req1_s || last_grant_r)) begin
                        state_r <= ST_GNT0;
                        grant_r <= GRANT_M0;
                    end else if (req1_s) begin
                        state_r <= ST_GNT1;
                        grant_r <= GRANT_M1;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= GRANT_NONE;
                    end
                end
                ST_GNT0: begin
                    if (hit_s || (req0_s && !s_waitrequest)) begin
                        state_r      <= ST_IDLE;
                        grant_r      <= GRANT_NONE;
                        last_grant_r <= 1'b0;
                    end else if (!req0_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= GRANT_NONE;
                    end else begin
                        state_r <= ST_GNT0;
                        grant_r <= GRANT_M0;
                    end
                end
                ST_GNT1: begin
                    if (hit_s || (req1_s && !s_waitrequest)) begin
                        state_r      <= ST_IDLE;
                        grant_r      <= GRANT_NONE;
                        last_grant_r <= 1'b1;
                    end else if (!req1_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= GRANT_NONE;
                    end else begin
                        state_r <= ST_GNT1;
                        grant_r <= GRANT_M1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= GRANT_NONE;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized scoreboard bench for mips_bus_arbiter: two master drivers, a stalling
// slave model, and a negedge monitor checking grants, data routing and the watchdog.
module tb_mips_bus_arbiter;

    localparam int          TO      = 4;
    localparam int          NTXN    = 40;
    localparam logic [31:0] RD_MASK = 32'h5A5AC3C3;
    localparam logic [31:0] ABORT_D = 32'hDEADBEEF;

    typedef struct {
        logic [1:0]  kind;   // 0 read, 1 write, 2 read+write
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        abort;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_read, m_write, m_wait;
    logic [31:0] m_address [2];
    logic [31:0] m_writedata [2];
    logic [3:0]  m_be [2];
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        timeout_err, err_clear;

    txn_t mq0[$], mq1[$], sq0[$], sq1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   drivers_done = 1'b0;

    // monitor model state
    logic [1:0] prev_grant = 2'b00, prev_req = 2'b00;
    logic       prev_done = 1'b0, last_served = 1'b1, exp_err = 1'b0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .m0_address     (m_address[0]),
        .m0_read        (m_read[0]),
        .m0_write       (m_write[0]),
        .m0_writedata   (m_writedata[0]),
        .m0_byteenable  (m_be[0]),
        .m0_waitrequest (m_wait[0]),
        .m0_readdata    (m0_rdata),
        .m1_address     (m_address[1]),
        .m1_read        (m_read[1]),
        .m1_write       (m_write[1]),
        .m1_writedata   (m_writedata[1]),
        .m1_byteenable  (m_be[1]),
        .m1_waitrequest (m_wait[1]),
        .m1_readdata    (m1_rdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .grant          (grant),
        .timeout_err    (timeout_err),
        .err_clear      (err_clear)
    );

    // Slave model: stalls address[2:0] cycles per transaction, zero-latency readdata
    logic [2:0] stall_cnt;
    assign s_waitrequest = (s_read || s_write) ? (stall_cnt < s_address[2:0]) : 1'b0;
    assign s_readdata    = s_address ^ RD_MASK;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 3'd0;
        else if ((s_read || s_write) && s_waitrequest) stall_cnt <= stall_cnt + 3'd1;
        else stall_cnt <= 3'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_master(input int x, output txn_t t, output bit ok);
        ok = 1'b0;
        t = '{default: '0};
        if (x == 0) begin
            if (mq0.size() > 0) begin t = mq0.pop_front(); ok = 1'b1; end
        end else begin
            if (mq1.size() > 0) begin t = mq1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic pop_slave(input int x, output txn_t t, output bit ok);
        ok = 1'b0;
        t = '{default: '0};
        if (x == 0) begin
            if (sq0.size() > 0) begin t = sq0.pop_front(); ok = 1'b1; end
        end else begin
            if (sq1.size() > 0) begin t = sq1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic drive_master(input int x, input int n);
        for (int i = 0; i < n; i++) begin
            txn_t t;
            int   gap;
            int   stall;
            bit   ok;
            gap = (i == 0) ? 0 : int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            t.kind      = 2'($urandom_range(0, 2));
            t.addr      = $urandom;
            t.addr[2:0] = 3'(stall);
            t.data      = $urandom;
            t.be        = 4'($urandom_range(0, 15));
            t.abort     = (stall >= TO);
            if (x == 0) begin
                mq0.push_back(t);
                if (!t.abort) sq0.push_back(t);
            end else begin
                mq1.push_back(t);
                if (!t.abort) sq1.push_back(t);
            end
            m_address[x]   = t.addr;
            m_writedata[x] = t.data;
            m_be[x]        = t.be;
            m_read[x]      = (t.kind != 2'd1);
            m_write[x]     = (t.kind != 2'd0);
            ok = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (!m_wait[x]) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL master%0d_done: actual stalled required completion", x);
            end
            @(posedge clk); #1;
            m_read[x]  = 1'b0;
            m_write[x] = 1'b0;
        end
    endtask

    // Scoreboard monitor: arbitration model, master responses, slave requests, error flag
    always @(negedge clk) begin
        logic [1:0]  exp_g;
        logic        done, abort_seen;
        txn_t        t;
        bit          ok;
        logic [31:0] exp_d;
        int          owner;
        if (mon_en) begin
            if (prev_grant == 2'b00) begin
                if (prev_req == 2'b11) exp_g = last_served ? 2'b01 : 2'b10;
                else exp_g = prev_req;
            end else begin
                exp_g = prev_done ? 2'b00 : prev_grant;
            end
            check("grant", {30'd0, grant}, {30'd0, exp_g});
            check("wait_exclusive", {31'd0, (m_wait == 2'b00)}, 32'd0);
            done = 1'b0;
            abort_seen = 1'b0;
            for (int x = 0; x < 2; x++) begin
                if ((m_read[x] || m_write[x]) && !m_wait[x]) begin
                    pop_master(x, t, ok);
                    check("master_response_expected", {31'd0, ok}, 32'd1);
                    if (ok) begin
                        exp_d = t.abort ? ABORT_D : (t.addr ^ RD_MASK);
                        check(x == 0 ? "m0_readdata" : "m1_readdata", x == 0 ? m0_rdata : m1_rdata, exp_d);
                        if (t.abort) abort_seen = 1'b1;
                    end
                    check("owner_grant", {30'd0, exp_g}, (x == 0) ? 32'd1 : 32'd2);
                    done = 1'b1;
                    last_served = x[0];
                end
            end
            if ((s_read || s_write) && !s_waitrequest) begin
                owner = (exp_g == 2'b10) ? 1 : 0;
                check("slave_strobe_owned", {31'd0, (exp_g != 2'b00)}, 32'd1);
                pop_slave(owner, t, ok);
                check("slave_request_expected", {31'd0, ok}, 32'd1);
                if (ok) begin
                    check("s_address", s_address, t.addr);
                    check("s_byteenable", {28'd0, s_byteenable}, {28'd0, t.be});
                    check("s_read", {31'd0, s_read}, {31'd0, (t.kind == 2'd0)});
                    check("s_write", {31'd0, s_write}, {31'd0, (t.kind != 2'd0)});
                    if (t.kind != 2'd0) check("s_writedata", s_writedata, t.data);
                end
            end
            check("timeout_err", {31'd0, timeout_err}, {31'd0, exp_err});
            if (abort_seen) exp_err = 1'b1;
            else if (err_clear) exp_err = 1'b0;
            prev_grant = exp_g;
            prev_done  = done;
            prev_req   = {m_read[1] | m_write[1], m_read[0] | m_write[0]};
        end
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit: actual expired required finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        err_clear = 1'b0;
        m_read = 2'b00;
        m_write = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_address[i] = 32'd0;
            m_writedata[i] = 32'd0;
            m_be[i] = 4'd0;
        end
        #1;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_s_strobes", {30'd0, s_read, s_write}, 32'd0);
        check("rst_s_address", s_address, 32'd0);
        check("rst_s_writedata", s_writedata, 32'd0);
        check("rst_s_byteenable", {28'd0, s_byteenable}, 32'd0);
        check("rst_m_wait", {30'd0, m_wait}, 32'd3);
        check("rst_m0_readdata", m0_rdata, 32'd0);
        check("rst_m1_readdata", m1_rdata, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        fork
            begin
                fork
                    drive_master(0, NTXN);
                    drive_master(1, NTXN);
                join
                drivers_done = 1'b1;
            end
            begin
                while (!drivers_done) begin
                    @(posedge clk); #1;
                    err_clear = ($urandom_range(0, 9) == 0);
                end
                err_clear = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        check("mq0_drained", mq0.size(), 32'd0);
        check("mq1_drained", mq1.size(), 32'd0);
        check("sq0_drained", sq0.size(), 32'd0);
        check("sq1_drained", sq1.size(), 32'd0);

        // Asynchronous reset while m0 write is stalled in GNT0
        @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        m_address[0] = 32'h0000_0107;
        m_writedata[0] = 32'h0BAD_F00D;
        m_be[0] = 4'hF;
        m_write[0] = 1'b1;
        @(posedge clk); #2;
        check("pre_reset_grant", {30'd0, grant}, 32'd1);
        check("pre_reset_s_write", {31'd0, s_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_grant", {30'd0, grant}, 32'd0);
        check("async_reset_s_write", {31'd0, s_write}, 32'd0);
        check("async_reset_m0_wait", {31'd0, m_wait[0]}, 32'd1);
        m_write[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_timeout_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clk); #1;
        m_address[0] = 32'h0000_0010;
        m_address[1] = 32'h0000_0020;
        m_read = 2'b11;
        @(posedge clk); #1;
        check("post_reset_tie_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        check("post_reset_m0_wait", {31'd0, m_wait[0]}, 32'd0);
        check("post_reset_m0_readdata", m0_rdata, 32'h0000_0010 ^ RD_MASK);
        check("post_reset_m1_wait", {31'd0, m_wait[1]}, 32'd1);
        @(posedge clk); #1;
        m_read[0] = 1'b0;
        @(posedge clk); #1;
        check("post_reset_m1_grant", {30'd0, grant}, 32'd2);
        m_read = 2'b00;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
